// File: rtl/msdap_pkg.sv
// Shared types and constants for the MSDAP serial input path.
//   deser_state_t : deserializer FSM states (IDLE, WAIT_FRAME, ARMED, SHIFT)
//   SAMPLE_WIDTH  : bits per sample per channel
package msdap_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ARMED      = 2'd2,
    SHIFT      = 2'd3
  } deser_state_t;

endpackage

// File: rtl/deser_shift_reg.sv
// Single-channel MSB-first shift register.
//   clk, reset : SCLK, synchronous active-high reset (q -> 0)
//   clear      : discard contents; when combined with shift, din becomes the
//                only bit held (start of a new word)
//   shift      : q <= {q[WIDTH-2:0], din}
//   din        : serial data bit
//   q          : register contents
module deser_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base = clear ? '0 : q_q;
    q_d  = base;
    if (shift) begin
      q_d = {base[WIDTH-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_input_deserializer.sv
// Converts the MSDAP stereo serial input (one bit per DCLK, MSB first) into
// parallel WIDTH-bit left/right samples in the SCLK domain.
//   clk, reset     : SCLK, synchronous active-high reset
//   enable         : capture enable; low returns to IDLE and drops a partial word
//   frame_start    : 1-cycle strobe, next bit_strobe carries the MSB
//   bit_strobe     : 1-cycle strobe, sample in_l/in_r this cycle
//   in_l, in_r     : serial data bits
//   dataL, dataR   : last complete samples, held between data_valid pulses
//   data_valid     : 1-cycle pulse, dataL/dataR updated this cycle
//   frame_error    : 1-cycle pulse, frame_start arrived mid-word
//   busy           : high in ARMED or SHIFT
//   state_dbg      : current FSM state
//
// Handshake: data_valid and frame_error are single-cycle, registered pulses
// with no back-pressure; the consumer must take dataL/dataR on the cycle
// data_valid is high (they stay held afterwards until the next word).
module serial_input_deserializer
  import msdap_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_start,
  input  logic             bit_strobe,
  input  logic             in_l,
  input  logic             in_r,
  output logic [WIDTH-1:0] dataL,
  output logic [WIDTH-1:0] dataR,
  output logic             data_valid,
  output logic             frame_error,
  output logic             busy,
  output deser_state_t     state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  deser_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_l_q, data_l_d;
  logic [WIDTH-1:0] data_r_q, data_r_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sh_clear;
  logic             sh_shift;

  // The shift registers only hold the first WIDTH-1 bits of a word; the LSB
  // is taken straight from the input pins into the output register.
  logic [WIDTH-2:0] sh_l;
  logic [WIDTH-2:0] sh_r;

  deser_shift_reg #(.WIDTH(WIDTH - 1)) u_shift_l (
    .clk   (clk),
    .reset (reset),
    .clear (sh_clear),
    .shift (sh_shift),
    .din   (in_l),
    .q     (sh_l)
  );

  deser_shift_reg #(.WIDTH(WIDTH - 1)) u_shift_r (
    .clk   (clk),
    .reset (reset),
    .clear (sh_clear),
    .shift (sh_shift),
    .din   (in_r),
    .q     (sh_r)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_l_d = data_l_q;
    data_r_d = data_r_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    sh_clear = 1'b0;
    sh_shift = 1'b0;

    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sh_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (frame_start && bit_strobe) begin
            sh_clear = 1'b1;
            sh_shift = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = SHIFT;
          end else if (frame_start) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (bit_strobe) begin
            sh_clear = 1'b1;
            sh_shift = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_strobe && (cnt_q == LAST_CNT)) begin
            // A frame_start on the LSB strobe is a clean back-to-back frame.
            data_l_d = {sh_l, in_l};
            data_r_d = {sh_r, in_r};
            valid_d  = 1'b1;
            cnt_d    = '0;
            state_d  = frame_start ? ARMED : WAIT_FRAME;
          end else if (frame_start) begin
            err_d    = 1'b1;
            sh_clear = 1'b1;
            if (bit_strobe) begin
              sh_shift = 1'b1;
              cnt_d    = CNT_W'(1);
            end else begin
              cnt_d   = '0;
              state_d = ARMED;
            end
          end else if (bit_strobe) begin
            sh_shift = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_l_q <= '0;
      data_r_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_l_q <= data_l_d;
      data_r_q <= data_r_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign dataL       = data_l_q;
  assign dataR       = data_r_q;
  assign data_valid  = valid_q;
  assign frame_error = err_q;
  assign busy        = (state_q == ARMED) || (state_q == SHIFT);
  assign state_dbg   = state_q;

endmodule
